rr_stream_mux: RTL and testbench

//   Parametrised N:1 stream multiplexer with valid/ready handshakes.
//   A round-robin arbiter selects one requesting channel per cycle.
//   The winner's data is captured in a registered output stage, so there is one cycle of latency.

---
 rtl/rr_stream_mux.sv | 162 ++++++++++++++++
 tb/tb_rr_stream_mux.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional packet lock (grant held until in_last) is enabled by defining RR_STREAM_MUX_LOCK_EN.
module rr_stream_mux #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in_valid,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_last,
  output logic [N-1:0]           in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(N)-1:0]   out_sel,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int unsigned SELW = $clog2(N);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  win;
  logic [SELW:0]    cand;
  logic             found;
  logic             space;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             locked;
  logic [SELW-1:0]  lock_ch;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic            lock_q, lock_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;

  assign locked  = lock_q;
  assign lock_ch = lock_ch_q;
`else
  assign locked  = 1'b0;
  assign lock_ch = '0;
`endif

  assign space = ~out_valid_q | out_ready;

  // Rotating search starting at ptr; candidates are folded back below N so
  // indices >= N are never granted for non-power-of-2 N.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (locked) begin
      win = lock_ch;
      if (in_valid[lock_ch]) begin
        grant[lock_ch] = 1'b1;
      end
    end else begin
      for (int unsigned o = 0; o < N; o++) begin
        cand = {1'b0, ptr_q} + (SELW+1)'(o);
        if (cand >= (SELW+1)'(N)) begin
          cand = cand - (SELW+1)'(N);
        end
        if (!found && in_valid[cand[SELW-1:0]]) begin
          found                  = 1'b1;
          win                    = cand[SELW-1:0];
          grant[cand[SELW-1:0]]  = 1'b1;
        end
      end
    end
  end

  // Reset gating keeps producers from seeing an accept while the mux is held in reset.
  assign in_ready = grant & {N{space & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef RR_STREAM_MUX_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = ~sel_last;
      lock_ch_d = win;
      // Pointer only moves when a packet completes.
      if (sel_last) begin
        ptr_d = (win == SELW'(N-1)) ? '0 : win + SELW'(1);
      end
    end
`else
    if (xfer) begin
      ptr_d = (win == SELW'(N-1)) ? '0 : win + SELW'(1);
    end
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = win;
      out_last_d  = sel_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef RR_STREAM_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel instance for the main sequence and
// a 3-channel instance for non-power-of-2 wrap.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;
  logic        out_ready;

  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_last3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_last3;
  logic        out_ready3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(4), .WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  rr_stream_mux #(.N(3), .WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_last   (in_last3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_last  (out_last3),
    .out_ready (out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".sel"},   {30'b0, out_sel},   {30'b0, s});
    chk({tag, ".data"},  {24'b0, out_data},  {24'b0, d});
  endtask

  initial begin
    // 1. Reset with all channels requesting
    rst_n      = 1'b0;
    in_valid   = 4'b1111;
    in_last    = 4'b0000;
    in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready  = 1'b1;
    in_valid3  = 3'b000;
    in_last3   = 3'b000;
    in_data3   = {8'hC2, 8'hC1, 8'hC0};
    out_ready3 = 1'b1;
    #2;
    chk_out("rst", 1'b0, 2'd0, 8'h00);
    chk("rst.in_ready", {28'b0, in_ready}, 32'h0);
    cyc();
    cyc();
    chk("rst_clk.valid", {31'b0, out_valid}, 32'h0);
    chk("rst_clk.in_ready", {28'b0, in_ready}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", {28'b0, in_ready}, 32'h1);

    // 2. Full-rate round robin 0,1,2,3,0
    cyc();
    chk_out("rr0", 1'b1, 2'd0, 8'hA0);
    chk("rr0.in_ready", {28'b0, in_ready}, 32'h2);
    cyc();
    chk_out("rr1", 1'b1, 2'd1, 8'hA1);
    cyc();
    chk_out("rr2", 1'b1, 2'd2, 8'hA2);
    cyc();
    chk_out("rr3", 1'b1, 2'd3, 8'hA3);
    cyc();
    chk_out("rr4", 1'b1, 2'd0, 8'hA0);

    // 3. Only ch2, then backpressure for 3 clocks
    in_valid       = 4'b0100;
    in_data[23:16] = 8'h5C;
    #1;
    chk("bp.pre_ready", {28'b0, in_ready}, 32'h4);
    cyc();
    chk_out("bp.load", 1'b1, 2'd2, 8'h5C);
    out_ready = 1'b0;
    #1;
    chk("bp.stall_ready", {28'b0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("bp.hold", 1'b1, 2'd2, 8'h5C);
      chk("bp.hold_ready", {28'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {28'b0, in_ready}, 32'h4);
    cyc();
    chk_out("bp.reload", 1'b1, 2'd2, 8'h5C);
    in_valid = 4'b0000;
    cyc();
    chk_out("drain", 1'b0, 2'd2, 8'h5C);

    // 4. ptr=3, requests on ch0 and ch2 -> wrap to ch0, then ch2
    in_valid       = 4'b0101;
    in_data[23:16] = 8'hA2;
    #1;
    chk("wrap.ready0", {28'b0, in_ready}, 32'h1);
    cyc();
    chk_out("wrap.ch0", 1'b1, 2'd0, 8'hA0);
    chk("wrap.ready2", {28'b0, in_ready}, 32'h4);
    cyc();
    chk_out("wrap.ch2", 1'b1, 2'd2, 8'hA2);

    // 5. Async reset while a beat is pending
    out_ready = 1'b0;
    cyc();
    chk_out("pend", 1'b1, 2'd2, 8'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 8'h00);
    chk("async_rst.in_ready", {28'b0, in_ready}, 32'h0);
    cyc();
    rst_n     = 1'b1;
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    #1;
    // ptr back at 0 picks ch1; a surviving ptr=3 would pick ch3
    chk("post_rst.ready", {28'b0, in_ready}, 32'h2);
    cyc();
    chk_out("post_rst.ch1", 1'b1, 2'd1, 8'hA1);

    // 6. Packet on ch1 while ch0 and ch3 also request
    in_valid = 4'b0001;
    cyc();
    chk_out("pre_pkt.ch0", 1'b1, 2'd0, 8'hA0);
    in_valid       = 4'b1011;
    in_data[15:8]  = 8'h11;
    in_last        = 4'b0000;
    cyc();
    chk_out("pkt.b0", 1'b1, 2'd1, 8'h11);
    chk("pkt.b0.last", {31'b0, out_last}, 32'h0);
    in_data[15:8] = 8'h12;
`ifdef RR_STREAM_MUX_LOCK_EN
    cyc();
    chk_out("pkt.b1", 1'b1, 2'd1, 8'h12);
    in_data[15:8] = 8'h13;
    in_last       = 4'b0010;
    cyc();
    chk_out("pkt.b2", 1'b1, 2'd1, 8'h13);
    chk("pkt.b2.last", {31'b0, out_last}, 32'h1);
    in_valid = 4'b1001;
    in_last  = 4'b0000;
    cyc();
    chk_out("pkt.after3", 1'b1, 2'd3, 8'hA3);
    cyc();
    chk_out("pkt.after0", 1'b1, 2'd0, 8'hA0);
`else
    cyc();
    chk_out("pkt.ch3", 1'b1, 2'd3, 8'hA3);
    cyc();
    chk_out("pkt.ch0", 1'b1, 2'd0, 8'hA0);
    cyc();
    chk_out("pkt.ch1", 1'b1, 2'd1, 8'h12);
`endif
    in_valid = 4'b0000;

    // N=3 instance: 0,1,2 then wrap to 0
    in_valid3 = 3'b111;
    #1;
    chk("n3.ready", {29'b0, in_ready3}, 32'h1);
    cyc();
    chk("n3.sel0", {30'b0, out_sel3}, 32'h0);
    chk("n3.data0", {24'b0, out_data3}, 32'hC0);
    cyc();
    chk("n3.sel1", {30'b0, out_sel3}, 32'h1);
    cyc();
    chk("n3.sel2", {30'b0, out_sel3}, 32'h2);
    chk("n3.data2", {24'b0, out_data3}, 32'hC2);
    cyc();
    chk("n3.sel_wrap", {30'b0, out_sel3}, 32'h0);
    chk("n3.valid", {31'b0, out_valid3}, 32'h1);
    in_valid3 = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
